spmmio_sdspi: RTL and testbench
===============================

# spmmio_sdspi

SPI master register block for the SD-card slot of the soft-processor MMIO space. It sits directly downstream of the MMIO address decoder, which hands it a 4-bit word index, a qualified chip select and byte lanes, and acknowledges every access in the same cycle. It drives the SD card in SPI mode 0 with a programmable clock divider and 8- or 32-bit transfers, and reports card-detect and write-protect state.

## Interface
Parameters:
- DIV_RESET, 8'hFF, reset value of CTRL.div (slow clock for card init)

Ports (big-endian bit numbering, bit 0 = MSB):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- adr  in  4  word index within the block
- cs  in  1  access strobe (already qualified with cyc/stb)
- sel  in  [0:3]  byte lane enables, lane 0 = d[0:7]
- we  in  1  write enable
- d  in  [0:31]  write data
- q  out  [0:31]  read data, combinational from adr and registers
- sdcard_cs  out  1  card select, active-low
- sdcard_cd  in  1  card detect, raw pin
- sdcard_wp  in  1  write protect, raw pin
- sdcard_sck  out  1  SPI clock, idle low
- sdcard_miso  in  1  serial in
- sdcard_mosi  out  1  serial out, idle high

## Operation
- Register map, by adr. Unmapped indices 3..15: q = 0, writes ignored.
- 0 CTRL (rw): d[31] = cs_active (sdcard_cs = ~cs_active); d[16:23] = div. A write applies cs_active at once, always. div updates only when not busy; otherwise it is ignored. div is written only if sel[2]; cs_active only if sel[3].
- 1 STATUS (ro): q[31] = busy; q[30] = cd_sync; q[29] = wp_sync; other bits 0.
- 2 DATA: a write while idle starts a transfer. A write while busy is ignored.
  - sel = 1111: 32-bit transfer, tx = d[0:31], sent MSB first.
  - Else if sel[3]: 8-bit transfer of d[24:31].
  - Other sel: ignored.
  - Read returns the 32-bit rx shift register. Each sampled MISO bit shifts in at bit 31, so after an 8-bit transfer the new byte is in q[24:31] and the older content has moved up 8 bits.
- FSM states:
  - IDLE → LOW on a DATA start.
  - LOW → HIGH when divcnt reaches div: SCK rises and MISO is sampled.
  - HIGH → LOW when divcnt reaches div: SCK falls and tx shifts, if bits remain.
  - HIGH → IDLE on the last bit.
  - divcnt reloads to 0 on every transition.
- MOSI = tx[0] while busy and 1 in IDLE. The first bit is presented on entry to LOW.
- cd and wp each pass through a 2-flop synchronizer.

## Timing
- Reset values: sdcard_cs = 1, sdcard_sck = 0, sdcard_mosi = 1, busy = 0, rx = 0, tx = 0, div = DIV_RESET, cs_active = 0, FSM = IDLE, synchronizers = 0.
- The DATA write edge loads tx, and busy reads 1 from the next cycle.
- Each SCK half-period lasts div+1 clk cycles.
- Transfer length: busy falls 2·(div+1)·bits cycles after the write edge. That is 16 cycles at div = 0 for 8 bits.
- MISO is sampled on the clk edge that raises SCK.
- If a DATA read and the final sample fall on the same edge, the read returns the pre-edge rx.
- A CTRL cs_active write during a transfer changes sdcard_cs immediately. Software is responsible for any CS timing.
- Asserting reset mid-transfer forces all reset values immediately. No partial byte survives.
- STATUS cd/wp reflect a pin change 2 cycles after the change.

## Structure
- Shared package spmmio_sdspi_pkg holds:
  - register indices REG_CTRL = 0, REG_STATUS = 1, REG_DATA = 2;
  - field positions (CTRL_CS = 31, CTRL_DIV = 16..23, ST_BUSY = 31, ST_CD = 30, ST_WP = 29);
  - the FSM state enum {IDLE, LOW, HIGH}.
- One sub-module, spmmio_spi_engine, holds the divider, FSM, bit counter, tx/rx shift registers, SCK and MOSI. The top level keeps register decode, CTRL storage and the synchronizers.

## Test plan
- Reset: pulse reset low, then read 0/1/2 → CTRL = 0x0000FF00, STATUS = 0 (pins low), DATA = 0. Pins sdcard_cs = 1, sck = 0, mosi = 1.
- 8-bit loopback: div = 0, MISO tied to MOSI, write DATA sel = 0001 d = 0x000000A5 → busy for exactly 16 cycles, 8 SCK rising edges, then DATA = 0x000000A5.
- 32-bit loopback: div = 0, write DATA sel = 1111 d = 0xDEADBEEF → busy for 64 cycles, then DATA = 0xDEADBEEF.
- Divider timing: div = 3, one byte → each SCK high and low phase is 4 cycles, busy lasts 64 cycles. A CTRL write of div = 0 during the transfer is ignored, and CTRL still reads div = 3 afterwards.
- Busy protection and reset: a second DATA write mid-transfer does not change the bits on MOSI. Asserting reset at bit 5 → sck = 0, mosi = 1, busy = 0 immediately.
- Status sync: toggle sdcard_cd 0→1 → STATUS[30] reads 1 on the 2nd cycle after the change, not the 1st. Writing STATUS leaves it unchanged.

Source files
------------

// File: rtl/spmmio_sdspi_pkg.sv
// Shared register map, field positions and SPI engine state encoding for the SD-card SPI block.
package spmmio_sdspi_pkg;

    localparam logic [3:0] REG_CTRL   = 4'd0;
    localparam logic [3:0] REG_STATUS = 4'd1;
    localparam logic [3:0] REG_DATA   = 4'd2;

    // Big-endian bit positions: bit 0 is the MSB of the 32-bit word.
    localparam int CTRL_CS     = 31;
    localparam int CTRL_DIV_HI = 16;
    localparam int CTRL_DIV_LO = 23;
    localparam int ST_BUSY     = 31;
    localparam int ST_CD       = 30;
    localparam int ST_WP       = 29;

    typedef enum logic [1:0] {IDLE, LOW, HIGH} spi_state_e;

    // Index of the final bit of a transfer.
    function automatic logic [4:0] last_bit(input logic len32);
        return len32 ? 5'd31 : 5'd7;
    endfunction

endpackage

// File: rtl/spmmio_sdspi_if.sv
// MMIO slave bus as seen downstream of the address decoder.
interface spmmio_sdspi_if;
    logic [3:0]  adr;
    logic        cs;
    logic [0:3]  sel;
    logic        we;
    logic [0:31] d;
    logic [0:31] q;

    modport master (output adr, cs, sel, we, d, input q);
    modport slave  (input adr, cs, sel, we, d, output q);
endinterface

// File: rtl/spmmio_spi_engine.sv
// SPI mode-0 shift engine: clock divider, IDLE/LOW/HIGH phase FSM, tx/rx shift registers.
module spmmio_spi_engine
    import spmmio_sdspi_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        len32_i,
    input  logic [0:31] tx_i,
    input  logic [7:0]  div_i,
    input  logic        miso_i,
    output logic        busy_o,
    output logic [0:31] rx_o,
    output logic        sck_o,
    output logic        mosi_o
);

    spi_state_e  state_q, state_d;
    logic [7:0]  divcnt_q, divcnt_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic [4:0]  last_q, last_d;
    logic [0:31] tx_q, tx_d;
    logic [0:31] rx_q, rx_d;
    logic        wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            divcnt_q <= '0;
            bitcnt_q <= '0;
            last_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else begin
            state_q  <= state_d;
            divcnt_q <= divcnt_d;
            bitcnt_q <= bitcnt_d;
            last_q   <= last_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

    assign wrap = (divcnt_q == div_i);

    always_comb begin
        state_d  = state_q;
        divcnt_d = divcnt_q;
        bitcnt_d = bitcnt_q;
        last_d   = last_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = LOW;
                    divcnt_d = '0;
                    bitcnt_d = '0;
                    last_d   = last_bit(len32_i);
                    // Byte transfers are left-justified so tx[0] is always the next bit out.
                    tx_d     = len32_i ? tx_i : {tx_i[24:31], 24'h0};
                end
            end
            LOW: begin
                if (wrap) begin
                    state_d  = HIGH;
                    divcnt_d = '0;
                    rx_d     = {rx_q[1:31], miso_i};
                end else begin
                    divcnt_d = divcnt_q + 8'd1;
                end
            end
            HIGH: begin
                if (wrap) begin
                    divcnt_d = '0;
                    if (bitcnt_q == last_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = LOW;
                        bitcnt_d = bitcnt_q + 5'd1;
                        tx_d     = {tx_q[1:31], 1'b0};
                    end
                end else begin
                    divcnt_d = divcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign sck_o  = (state_q == HIGH);
    assign mosi_o = (state_q == IDLE) ? 1'b1 : tx_q[0];
    assign rx_o   = rx_q;

endmodule

// File: rtl/spmmio_sdspi.sv
// SD-card SPI master register block: CTRL/STATUS/DATA decode, card-select, pin synchronizers.
module spmmio_sdspi
    import spmmio_sdspi_pkg::*;
#(
    parameter logic [7:0] DIV_RESET = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    spmmio_sdspi_if.slave    bus,
    output logic             sdcard_cs,
    input  logic             sdcard_cd,
    input  logic             sdcard_wp,
    output logic             sdcard_sck,
    input  logic             sdcard_miso,
    output logic             sdcard_mosi
);

    logic        cs_active_q, cs_active_d;
    logic [7:0]  div_q, div_d;
    logic [1:0]  cd_q, wp_q;
    logic        busy;
    logic [0:31] rx;
    logic        wr_en, start, len32;
    logic [0:31] rdata;

    assign wr_en = bus.cs & bus.we;
    assign start = wr_en && (bus.adr == REG_DATA) && !busy && bus.sel[3];
    assign len32 = (bus.sel == 4'b1111);

    // Divider is frozen while shifting so a transfer keeps a constant bit rate.
    always_comb begin
        cs_active_d = cs_active_q;
        div_d       = div_q;
        if (wr_en && (bus.adr == REG_CTRL)) begin
            if (bus.sel[3])
                cs_active_d = bus.d[CTRL_CS];
            if (bus.sel[2] && !busy)
                div_d = bus.d[CTRL_DIV_HI:CTRL_DIV_LO];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_active_q <= 1'b0;
            div_q       <= DIV_RESET;
            cd_q        <= '0;
            wp_q        <= '0;
        end else begin
            cs_active_q <= cs_active_d;
            div_q       <= div_d;
            cd_q        <= {cd_q[0], sdcard_cd};
            wp_q        <= {wp_q[0], sdcard_wp};
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.adr)
            REG_CTRL: begin
                rdata[CTRL_CS]                 = cs_active_q;
                rdata[CTRL_DIV_HI:CTRL_DIV_LO] = div_q;
            end
            REG_STATUS: begin
                rdata[ST_BUSY] = busy;
                rdata[ST_CD]   = cd_q[1];
                rdata[ST_WP]   = wp_q[1];
            end
            REG_DATA: rdata = rx;
            default:  rdata = '0;
        endcase
    end

    assign bus.q     = rdata;
    assign sdcard_cs = ~cs_active_q;

    spmmio_spi_engine u_engine (
        .clk     (clk),
        .rst_n   (reset),
        .start_i (start),
        .len32_i (len32),
        .tx_i    (bus.d),
        .div_i   (div_q),
        .miso_i  (sdcard_miso),
        .busy_o  (busy),
        .rx_o    (rx),
        .sck_o   (sdcard_sck),
        .mosi_o  (sdcard_mosi)
    );

endmodule

// File: tb/tb_spmmio_sdspi.sv
// Directed and randomized bench for spmmio_sdspi against a transfer-level reference model.
module tb_spmmio_sdspi;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sdcard_cs, sdcard_cd, sdcard_wp, sdcard_sck, sdcard_miso, sdcard_mosi;
    logic loop_en = 1'b1;
    logic miso_const = 1'b0;

    int n_checks = 0;
    int n_pass = 0;
    int sck_rises = 0;
    logic [31:0] mosi_word = '0;
    logic [31:0] rx_model = '0;
    logic [31:0] rv;
    int cyc, bad;

    spmmio_sdspi_if bus ();

    spmmio_sdspi #(.DIV_RESET(8'hFF)) dut (
        .clk         (clk),
        .reset       (reset_n),
        .bus         (bus),
        .sdcard_cs   (sdcard_cs),
        .sdcard_cd   (sdcard_cd),
        .sdcard_wp   (sdcard_wp),
        .sdcard_sck  (sdcard_sck),
        .sdcard_miso (sdcard_miso),
        .sdcard_mosi (sdcard_mosi)
    );

    always #5 clk = ~clk;

    assign sdcard_miso = loop_en ? sdcard_mosi : miso_const;

    always @(posedge sdcard_sck) begin
        sck_rises = sck_rises + 1;
        mosi_word = {mosi_word[30:0], sdcard_mosi};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] s, input logic [31:0] v);
        @(negedge clk);
        bus.adr = a; bus.sel = s; bus.d = v; bus.cs = 1'b1; bus.we = 1'b1;
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.adr = a; bus.cs = 1'b0; bus.we = 1'b0;
        #1 v = bus.q;
    endtask

    // Transfer-level model: bit count from lane enables, rx update from the bits shifted in.
    function automatic int xfer_bits(input logic [3:0] s);
        if (s == 4'hF) return 32;
        if (s[0]) return 8;
        return 0;
    endfunction

    function automatic logic [31:0] rx_after(input logic [31:0] old, input logic [31:0] inbits, input int bits);
        if (bits == 32) return inbits;
        if (bits == 8) return {old[23:0], inbits[7:0]};
        return old;
    endfunction

    function automatic logic [31:0] sent_bits(input logic [31:0] v, input int bits);
        if (bits == 32) return v;
        if (bits == 8) return {24'h0, v[7:0]};
        return 32'h0;
    endfunction

    // mid_op 1: CTRL div=0 write mid-transfer; mid_op 2: second DATA write mid-transfer.
    task automatic run_xfer(input logic [3:0] s, input logic [31:0] v, input int dv,
                            input int mid_op, input int mid_at, output int cycles, output int bad_runs);
        logic prev;
        int run;
        sck_rises = 0;
        mosi_word = '0;
        wr(REG_DATA_A, s, v);
        bus.adr = 4'd1;
        #1;
        cycles = 0; bad_runs = 0; run = 0; prev = sdcard_sck;
        while (cycles < 3000 && !(bus.adr == 4'd1 && bus.q[31] == 1'b0)) begin
            cycles++;
            if (sdcard_sck == prev) run++;
            else begin
                if (run != dv + 1) bad_runs++;
                prev = sdcard_sck;
                run = 1;
            end
            if (mid_op != 0 && cycles == mid_at) begin
                bus.cs = 1'b1; bus.we = 1'b1;
                if (mid_op == 1) begin bus.adr = 4'd0; bus.sel = 4'b0010; bus.d = 32'h0; end
                else begin bus.adr = 4'd2; bus.sel = 4'b0001; bus.d = 32'h0000003C; end
            end else begin
                bus.cs = 1'b0; bus.we = 1'b0; bus.adr = 4'd1;
            end
            @(negedge clk);
            #1;
        end
        if (cycles > 0 && run != dv + 1) bad_runs++;
    endtask

    localparam logic [3:0] REG_DATA_A = 4'd2;

    initial begin
        logic [3:0] sel_tab [6];
        logic [3:0] s;
        logic [31:0] v;
        int dv, bits, n;
        sel_tab = '{4'hF, 4'h1, 4'h3, 4'hB, 4'h2, 4'h4};
        bus.adr = '0; bus.cs = 1'b0; bus.we = 1'b0; bus.sel = '0; bus.d = '0;
        sdcard_cd = 1'b0; sdcard_wp = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        rd(4'd0, rv); check("rst_ctrl", rv, 32'h0000FF00);
        rd(4'd1, rv); check("rst_status", rv, 32'h0);
        rd(4'd2, rv); check("rst_data", rv, 32'h0);
        check("rst_pin_cs", {31'h0, sdcard_cs}, 32'h1);
        check("rst_pin_sck", {31'h0, sdcard_sck}, 32'h0);
        check("rst_pin_mosi", {31'h0, sdcard_mosi}, 32'h1);

        wr(4'd0, 4'b0011, 32'h00000001);
        rd(4'd0, rv); check("ctrl_div0_cs", rv, 32'h00000001);
        check("pin_cs_active", {31'h0, sdcard_cs}, 32'h0);

        run_xfer(4'b0001, 32'h000000A5, 0, 0, 0, cyc, bad);
        rx_model = rx_after(rx_model, 32'hA5, 8);
        check("b8_busy_cycles", cyc, 16);
        check("b8_sck_rises", sck_rises, 8);
        check("b8_mosi_bits", mosi_word, 32'h000000A5);
        rd(4'd2, rv); check("b8_rx", rv, rx_model);

        run_xfer(4'b1111, 32'hDEADBEEF, 0, 0, 0, cyc, bad);
        rx_model = rx_after(rx_model, 32'hDEADBEEF, 32);
        check("b32_busy_cycles", cyc, 64);
        check("b32_sck_rises", sck_rises, 32);
        rd(4'd2, rv); check("b32_rx", rv, rx_model);

        wr(4'd0, 4'b0010, 32'h00000300);
        run_xfer(4'b0001, 32'h0000005A, 3, 1, 10, cyc, bad);
        rx_model = rx_after(rx_model, 32'h5A, 8);
        check("div3_busy_cycles", cyc, 64);
        check("div3_phase_len", bad, 0);
        check("div3_sck_rises", sck_rises, 8);
        rd(4'd2, rv); check("div3_rx", rv, rx_model);
        rd(4'd0, rv); check("div3_ctrl_kept", rv, 32'h00000301);

        wr(4'd0, 4'b0010, 32'h00000000);
        run_xfer(4'b0001, 32'h000000A5, 0, 2, 5, cyc, bad);
        rx_model = rx_after(rx_model, 32'hA5, 8);
        check("prot_busy_cycles", cyc, 16);
        check("prot_mosi_bits", mosi_word, 32'h000000A5);
        rd(4'd2, rv); check("prot_rx", rv, rx_model);

        loop_en = 1'b0; miso_const = 1'b0;
        run_xfer(4'b0001, 32'h000000FF, 0, 0, 0, cyc, bad);
        rx_model = rx_after(rx_model, 32'h0, 8);
        rd(4'd2, rv); check("miso0_rx", rv, rx_model);
        miso_const = 1'b1;
        run_xfer(4'b0001, 32'h00000000, 0, 0, 0, cyc, bad);
        rx_model = rx_after(rx_model, 32'hFFFFFFFF, 8);
        rd(4'd2, rv); check("miso1_rx", rv, rx_model);
        loop_en = 1'b1;

        for (int i = 0; i < 8; i++) begin
            dv = $urandom_range(0, 2);
            s = sel_tab[$urandom_range(0, 5)];
            v = $urandom;
            bits = xfer_bits(s);
            wr(4'd0, 4'b0010, 32'(dv) << 8);
            run_xfer(s, v, dv, 0, 0, cyc, bad);
            rx_model = rx_after(rx_model, v, bits);
            check("rnd_busy_cycles", cyc, 2 * (dv + 1) * bits);
            check("rnd_mosi_bits", mosi_word, sent_bits(v, bits));
            rd(4'd2, rv); check("rnd_rx", rv, rx_model);
        end

        wr(4'd0, 4'b0011, 32'h00000001);
        sck_rises = 0;
        wr(4'd2, 4'b1111, 32'h12345678);
        n = 0;
        while (sck_rises < 3 && n < 200) begin @(negedge clk); n++; end
        wr(4'd0, 4'b0001, 32'h00000000);
        #1 check("cs_drop_mid_xfer", {31'h0, sdcard_cs}, 32'h1);
        n = 0;
        while (sck_rises < 5 && n < 200) begin @(negedge clk); n++; end
        check("reached_bit5", sck_rises, 5);
        @(negedge clk);
        reset_n = 1'b0;
        bus.adr = 4'd1;
        #1;
        check("rstmid_sck", {31'h0, sdcard_sck}, 32'h0);
        check("rstmid_mosi", {31'h0, sdcard_mosi}, 32'h1);
        check("rstmid_status", bus.q, 32'h0);
        bus.adr = 4'd2;
        #1 check("rstmid_data", bus.q, 32'h0);
        bus.adr = 4'd0;
        #1 check("rstmid_ctrl", bus.q, 32'h0000FF00);
        @(negedge clk);
        reset_n = 1'b1;
        rx_model = '0;

        rd(4'd1, rv);
        sdcard_cd = 1'b1;
        @(negedge clk); #1 check("cd_sync_1st", bus.q, 32'h0);
        @(negedge clk); #1 check("cd_sync_2nd", bus.q, 32'h00000002);
        sdcard_wp = 1'b1;
        @(negedge clk);
        @(negedge clk); #1 check("wp_sync_2nd", bus.q, 32'h00000006);
        wr(4'd1, 4'b1111, 32'hFFFFFFFF);
        rd(4'd1, rv); check("status_ro", rv, 32'h00000006);

        wr(4'd5, 4'b1111, 32'hFFFFFFFF);
        rd(4'd5, rv); check("unmapped_read", rv, 32'h0);
        rd(4'd0, rv); check("unmapped_ctrl", rv, 32'h0000FF00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
